// File: rtl/oled_pattern_gen_if.sv
// Pixel-side bundle between the OLED video driver and the test-pattern source.
// The master side drives coordinates and controls. The slave side returns colour and status.
interface oled_pattern_gen_if #(
    parameter int C_x_bits = 7,
    parameter int C_y_bits = 8
);
    logic [C_x_bits-1:0] x;
    logic [C_y_bits-1:0] y;
    logic                btn;
    logic                pause;
    logic [15:0]         color;
    logic [1:0]          mode;
    logic                frame_tick;

    modport master (
        output x, y, btn, pause,
        input  color, mode, frame_tick
    );

    modport slave (
        input  x, y, btn, pause,
        output color, mode, frame_tick
    );
endinterface

// File: rtl/oled_pattern_gen.sv
// Animated RGB565 test-pattern source: checker / bars / gradient / solid, selected by a debounced button,
// with scrolling driven by frame starts detected in the coordinate stream.
module oled_pattern_gen #(
    parameter int C_x_bits        = 7,
    parameter int C_y_bits        = 8,
    parameter int C_sq_log2       = 3,
    parameter int C_scroll_div    = 4,
    parameter int C_debounce_bits = 16
) (
    input  logic             clki,
    input  logic             resn,
    oled_pattern_gen_if.slave bus
);
    typedef enum logic [1:0] {
        PAT_CHECKER  = 2'd0,
        PAT_BARS     = 2'd1,
        PAT_GRADIENT = 2'd2,
        PAT_SOLID    = 2'd3
    } pattern_e;

    localparam int              DIV_W    = (C_scroll_div > 1) ? $clog2(C_scroll_div) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(C_scroll_div - 1);

    logic [C_y_bits-1:0]        prev_y;
    logic                       frame_start;
    logic                       frame_tick_q;
    logic [DIV_W-1:0]           div_cnt;
    logic [7:0]                 offset;

    logic                       btn_meta;
    logic                       btn_sync;
    logic                       btn_acc;
    logic                       btn_acc_d;
    logic [C_debounce_bits-1:0] db_cnt;
    pattern_e                   mode_q;

    logic [C_x_bits-1:0]        xs;
    logic [C_y_bits-1:0]        ys;
    logic [15:0]                pattern;
    logic [15:0]                color_q;

    function automatic logic [15:0] palette(input logic [2:0] i);
        return {{5{i[2]}}, {6{i[1]}}, {5{i[0]}}};
    endfunction

    assign frame_start = (bus.y == '0) && (prev_y != '0);

    always_ff @(posedge clki or negedge resn) begin
        if (!resn) begin
            prev_y       <= '0;
            frame_tick_q <= 1'b0;
            div_cnt      <= '0;
            offset       <= '0;
        end else begin
            prev_y       <= bus.y;
            frame_tick_q <= frame_start;
            if (frame_start && !bus.pause) begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                    offset  <= offset + 8'd1;
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end
        end
    end

    // Counter only runs while the synchronised level disagrees with the accepted one,
    // so any bounce back to the accepted level restarts the stability window.
    always_ff @(posedge clki or negedge resn) begin
        if (!resn) begin
            btn_meta  <= 1'b0;
            btn_sync  <= 1'b0;
            btn_acc   <= 1'b0;
            btn_acc_d <= 1'b0;
            db_cnt    <= '0;
            mode_q    <= PAT_CHECKER;
        end else begin
            btn_meta  <= bus.btn;
            btn_sync  <= btn_meta;
            btn_acc_d <= btn_acc;
            if (btn_sync == btn_acc) begin
                db_cnt <= '0;
            end else if (db_cnt == '1) begin
                btn_acc <= btn_sync;
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + C_debounce_bits'(1);
            end
            if (btn_acc && !btn_acc_d) begin
                mode_q <= pattern_e'(mode_q + 2'd1);
            end
        end
    end

    always_comb begin
        xs      = bus.x + C_x_bits'(offset);
        ys      = bus.y + C_y_bits'(offset);
        pattern = '0;
        case (mode_q)
            PAT_CHECKER:  pattern = (xs[C_sq_log2] ^ ys[C_sq_log2]) ? 16'h07E0 : 16'hF800;
            PAT_BARS:     pattern = palette(bus.x[C_x_bits-1 -: 3]);
            PAT_GRADIENT: pattern = {bus.x[C_x_bits-1 -: 5], 6'd0, bus.y[C_y_bits-3 -: 5]};
            PAT_SOLID:    pattern = palette(offset[2:0]);
            default:      pattern = '0;
        endcase
    end

    always_ff @(posedge clki or negedge resn) begin
        if (!resn) begin
            color_q <= '0;
        end else begin
            color_q <= pattern;
        end
    end

    assign bus.color      = color_q;
    assign bus.mode       = mode_q;
    assign bus.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_oled_pattern_gen.sv
// Directed bench for oled_pattern_gen: reset, frame detection, scrolling, wrap, debounce,
// pattern colours and asynchronous reset, with hand-computed expectations.
module tb_oled_pattern_gen;
    logic clk = 1'b0;
    logic resn;
    int   checks = 0;
    int   fails  = 0;
    int   ticks  = 0;

    always #5 clk = ~clk;

    oled_pattern_gen_if #(.C_x_bits(7), .C_y_bits(8)) bus ();

    oled_pattern_gen #(
        .C_x_bits(7),
        .C_y_bits(8),
        .C_sq_log2(3),
        .C_scroll_div(4),
        .C_debounce_bits(4)
    ) dut (
        .clki(clk),
        .resn(resn),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
        if (bus.frame_tick) ticks++;
    endtask

    task automatic do_reset();
        resn      = 1'b0;
        bus.btn   = 1'b0;
        bus.pause = 1'b0;
        bus.x     = '0;
        bus.y     = '0;
        repeat (2) @(posedge clk);
        #1 resn = 1'b1;
        ticks = 0;
    endtask

    task automatic fast_frames(input int n);
        repeat (n) begin
            bus.y = 8'd1;
            step();
            bus.y = 8'd0;
            step();
        end
    endtask

    task automatic full_frames(input int n);
        repeat (n) begin
            for (int r = 1; r < 64; r++) begin
                bus.y = 8'(r);
                step();
            end
            bus.y = 8'd0;
            step();
        end
    endtask

    task automatic press(input int hold, input int rel);
        bus.btn = 1'b1;
        repeat (hold) step();
        bus.btn = 1'b0;
        repeat (rel) step();
    endtask

    task automatic test_reset();
        resn      = 1'b0;
        bus.x     = 7'd5;
        bus.y     = 8'd9;
        bus.btn   = 1'b0;
        bus.pause = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.color !== 16'h0000) begin
            fails++;
            $display("FAIL reset_color: got %h expected %h", bus.color, 16'h0000);
        end
        checks++;
        if (bus.mode !== 2'd0) begin
            fails++;
            $display("FAIL reset_mode: got %0d expected %0d", bus.mode, 0);
        end
        checks++;
        if (bus.frame_tick !== 1'b0) begin
            fails++;
            $display("FAIL reset_tick: got %b expected %b", bus.frame_tick, 1'b0);
        end
        bus.x = 7'd8;
        bus.y = 8'd0;
        resn  = 1'b1;
        step();
        checks++;
        if (bus.color !== 16'h07E0) begin
            fails++;
            $display("FAIL release_green: got %h expected %h", bus.color, 16'h07E0);
        end
        checks++;
        if (bus.frame_tick !== 1'b0) begin
            fails++;
            $display("FAIL release_no_tick: got %b expected %b", bus.frame_tick, 1'b0);
        end
        bus.x = 7'd0;
        step();
        checks++;
        if (bus.color !== 16'hF800) begin
            fails++;
            $display("FAIL release_red: got %h expected %h", bus.color, 16'hF800);
        end
    endtask

    task automatic test_frame_scroll();
        do_reset();
        bus.y = 8'd5;
        step();
        bus.y = 8'd0;
        step();
        checks++;
        if (bus.frame_tick !== 1'b1) begin
            fails++;
            $display("FAIL tick_assert: got %b expected %b", bus.frame_tick, 1'b1);
        end
        step();
        checks++;
        if (bus.frame_tick !== 1'b0) begin
            fails++;
            $display("FAIL tick_one_cycle: got %b expected %b", bus.frame_tick, 1'b0);
        end

        do_reset();
        full_frames(8);
        checks++;
        if (ticks !== 8) begin
            fails++;
            $display("FAIL scroll_tick_count: got %0d expected %0d", ticks, 8);
        end
        bus.x = 7'd6;
        repeat (2) step();
        checks++;
        if (bus.color !== 16'h07E0) begin
            fails++;
            $display("FAIL scroll_offset2: got %h expected %h", bus.color, 16'h07E0);
        end

        do_reset();
        bus.pause = 1'b1;
        full_frames(8);
        checks++;
        if (ticks !== 8) begin
            fails++;
            $display("FAIL pause_tick_count: got %0d expected %0d", ticks, 8);
        end
        bus.pause = 1'b0;
        bus.x     = 7'd6;
        repeat (2) step();
        checks++;
        if (bus.color !== 16'hF800) begin
            fails++;
            $display("FAIL pause_offset0: got %h expected %h", bus.color, 16'hF800);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        fast_frames(1024);
        bus.x = 7'd6;
        repeat (2) step();
        checks++;
        if (bus.color !== 16'hF800) begin
            fails++;
            $display("FAIL wrap_offset0: got %h expected %h", bus.color, 16'hF800);
        end
        fast_frames(4);
        bus.x = 7'd7;
        repeat (2) step();
        checks++;
        if (bus.color !== 16'h07E0) begin
            fails++;
            $display("FAIL wrap_offset1: got %h expected %h", bus.color, 16'h07E0);
        end
        bus.x = 7'd127;
        bus.y = 8'd7;
        step();
        checks++;
        if (bus.color !== 16'h07E0) begin
            fails++;
            $display("FAIL checker_x_wrap: got %h expected %h", bus.color, 16'h07E0);
        end
        bus.x = 7'd120;
        step();
        checks++;
        if (bus.color !== 16'hF800) begin
            fails++;
            $display("FAIL checker_x120: got %h expected %h", bus.color, 16'hF800);
        end
    endtask

    task automatic test_debounce();
        int         changes;
        logic [1:0] prev_mode;
        do_reset();
        repeat (3) press(10, 10);
        repeat (10) step();
        checks++;
        if (bus.mode !== 2'd0) begin
            fails++;
            $display("FAIL bounce_ignored: got %0d expected %0d", bus.mode, 0);
        end

        bus.btn = 1'b1;
        repeat (18) step();
        checks++;
        if (bus.mode !== 2'd0) begin
            fails++;
            $display("FAIL press_not_early: got %0d expected %0d", bus.mode, 0);
        end
        step();
        checks++;
        if (bus.mode !== 2'd1) begin
            fails++;
            $display("FAIL press_latency: got %0d expected %0d", bus.mode, 1);
        end
        changes   = 0;
        prev_mode = bus.mode;
        repeat (21) begin
            step();
            if (bus.mode != prev_mode) changes++;
            prev_mode = bus.mode;
        end
        bus.btn = 1'b0;
        repeat (40) begin
            step();
            if (bus.mode != prev_mode) changes++;
            prev_mode = bus.mode;
        end
        checks++;
        if (changes !== 0) begin
            fails++;
            $display("FAIL hold_release_changes: got %0d expected %0d", changes, 0);
        end
        checks++;
        if (bus.mode !== 2'd1) begin
            fails++;
            $display("FAIL release_mode: got %0d expected %0d", bus.mode, 1);
        end
        repeat (3) press(40, 40);
        checks++;
        if (bus.mode !== 2'd0) begin
            fails++;
            $display("FAIL mode_wrap: got %0d expected %0d", bus.mode, 0);
        end
    endtask

    task automatic test_patterns();
        do_reset();
        fast_frames(24);
        press(30, 30);
        bus.x = 7'd80;
        repeat (2) step();
        checks++;
        if (bus.mode !== 2'd1) begin
            fails++;
            $display("FAIL bars_mode: got %0d expected %0d", bus.mode, 1);
        end
        checks++;
        if (bus.color !== 16'hF81F) begin
            fails++;
            $display("FAIL bars_color: got %h expected %h", bus.color, 16'hF81F);
        end
        press(30, 30);
        bus.x = 7'd95;
        bus.y = 8'd63;
        repeat (2) step();
        checks++;
        if (bus.color !== 16'hB81F) begin
            fails++;
            $display("FAIL gradient_color: got %h expected %h", bus.color, 16'hB81F);
        end
        press(30, 30);
        checks++;
        if (bus.mode !== 2'd3) begin
            fails++;
            $display("FAIL solid_mode: got %0d expected %0d", bus.mode, 3);
        end
        checks++;
        if (bus.color !== 16'hFFE0) begin
            fails++;
            $display("FAIL solid_color: got %h expected %h", bus.color, 16'hFFE0);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        press(30, 30);
        press(30, 30);
        checks++;
        if (bus.mode !== 2'd2) begin
            fails++;
            $display("FAIL pre_reset_mode: got %0d expected %0d", bus.mode, 2);
        end
        bus.btn = 1'b1;
        repeat (8) step();
        #2 resn = 1'b0;
        #1;
        checks++;
        if (bus.mode !== 2'd0) begin
            fails++;
            $display("FAIL async_mode: got %0d expected %0d", bus.mode, 0);
        end
        checks++;
        if (bus.color !== 16'h0000) begin
            fails++;
            $display("FAIL async_color: got %h expected %h", bus.color, 16'h0000);
        end
        checks++;
        if (bus.frame_tick !== 1'b0) begin
            fails++;
            $display("FAIL async_tick: got %b expected %b", bus.frame_tick, 1'b0);
        end
        bus.btn = 1'b0;
        repeat (3) step();
        resn  = 1'b1;
        bus.x = 7'd8;
        bus.y = 8'd0;
        repeat (40) step();
        checks++;
        if (bus.mode !== 2'd0) begin
            fails++;
            $display("FAIL post_reset_mode: got %0d expected %0d", bus.mode, 0);
        end
        checks++;
        if (bus.color !== 16'h07E0) begin
            fails++;
            $display("FAIL post_reset_color: got %h expected %h", bus.color, 16'h07E0);
        end
    endtask

    initial begin
        test_reset();
        test_frame_scroll();
        test_wrap();
        test_debounce();
        test_patterns();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
